// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared definitions for the serial adder and its driver.
//   DEF_WIDTH : default operand width
//   state_t   : driver FSM state encoding
package serial_add_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_SHIFT, ST_DRAIN, ST_DONE} state_t;
endpackage

// File: rtl/ser_shift_reg.sv
// ser_shift_reg: parallel-load, right-shift register presenting its LSB.
//   clk, rst : clock, asynchronous active-high reset
//   load_i   : load data_i (takes priority over shift_i)
//   shift_i  : shift right by one, zero fill
//   data_i   : parallel load value
//   bit_o    : current LSB
module ser_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o
);
  logic [WIDTH-1:0] sr_q, sr_d;
  always_comb sr_d = load_i ? data_i : shift_i ? {1'b0, sr_q[WIDTH-1:1]} : sr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sr_q <= '0;
    else sr_q <= sr_d;
  assign bit_o = sr_q[0];
endmodule

// File: rtl/serial_add_driver.sv
// serial_add_driver: feeds operand pairs LSB-first to a registered serial adder and assembles the sum.
//   clk, rst               : clock, asynchronous active-high reset
//   start_valid/ready      : operand handshake, op_a/op_b parallel operands
//   ser_clr, ser_a, ser_b  : to the serial adder (ser_clr is its synchronous clear)
//   ser_sum, ser_carry     : registered sum/carry from the serial adder
//   res_valid/ready, result: {carry-out, sum} handshake
//   chk_err                : only with SERIAL_ADD_DRIVER_CHECK_EN, one-cycle pulse on DONE entry
//                            when the serial result disagrees with a parallel add
module serial_add_driver
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ser_clr,
  output logic             ser_a,
  output logic             ser_b,
  input  logic             ser_sum,
  input  logic             ser_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   result
`ifdef SERIAL_ADD_DRIVER_CHECK_EN
  ,
  output logic             chk_err
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic cout_q, cout_d;
  logic accept, shift, cap, a_bit, b_bit;
  assign accept = state_q == ST_IDLE && start_valid;
  assign shift = state_q == ST_SHIFT;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= ST_IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == ST_IDLE  ? (start_valid ? ST_CLEAR : ST_IDLE) :
              state_q == ST_CLEAR ? ST_SHIFT :
              state_q == ST_SHIFT ? (cnt_q == LAST ? ST_DRAIN : ST_SHIFT) :
              state_q == ST_DRAIN ? ST_DONE :
              state_q == ST_DONE  ? (res_ready ? ST_IDLE : ST_DONE) : ST_IDLE;
  // rst gating keeps the handshake closed and the adder cleared while reset is held
  always_comb begin
    start_ready = state_q == ST_IDLE && !rst;
    ser_clr = state_q == ST_CLEAR || rst;
    ser_a = shift && a_bit;
    ser_b = shift && b_bit;
    res_valid = state_q == ST_DONE;
  end
  ser_shift_reg #(.WIDTH(WIDTH)) u_sr_a (
    .clk(clk), .rst(rst), .load_i(accept), .shift_i(shift), .data_i(op_a), .bit_o(a_bit)
  );
  ser_shift_reg #(.WIDTH(WIDTH)) u_sr_b (
    .clk(clk), .rst(rst), .load_i(accept), .shift_i(shift), .data_i(op_b), .bit_o(b_bit)
  );
  // adder output lags by one cycle: bit k-1 arrives in SHIFT cycle k, the MSB and carry in DRAIN;
  // shifting in from the top leaves bit 0 at position 0 after exactly WIDTH captures
  always_comb begin
    cnt_d = accept ? '0 : (shift && cnt_q != LAST) ? cnt_q + CW'(1) : cnt_q;
    cap = (shift && cnt_q != '0) || state_q == ST_DRAIN;
    sum_d = cap ? {ser_sum, sum_q[WIDTH-1:1]} : sum_q;
    cout_d = state_q == ST_DRAIN ? ser_carry : cout_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
    end
  assign result = {cout_q, sum_q};
`ifdef SERIAL_ADD_DRIVER_CHECK_EN
  logic [WIDTH-1:0] la_q, lb_q;
  logic chk_q, chk_d;
  always_comb chk_d = state_q == ST_DRAIN && ({ser_carry, sum_d} != {1'b0, la_q} + {1'b0, lb_q});
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      la_q <= '0;
      lb_q <= '0;
      chk_q <= 1'b0;
    end else begin
      la_q <= accept ? op_a : la_q;
      lb_q <= accept ? op_b : lb_q;
      chk_q <= chk_d;
    end
  assign chk_err = chk_q;
`endif
endmodule

// File: tb/tb_serial_add_driver.sv
// tb_serial_add_driver: driver looped to a behavioural serial adder, scoreboard-checked.
module tb_serial_add_driver;
  localparam int W = 8;
  logic clk = 0, rst = 1, start_valid = 0, start_ready, res_valid, res_ready = 0;
  logic [W-1:0] op_a = 0, op_b = 0;
  logic ser_clr, ser_a, ser_b, ser_sum, ser_carry;
  logic [W:0] result;
  logic add_s = 0, add_c = 0;
  bit force0 = 0, hold = 0;
  int cyc = 0, n_chk = 0, n_pass = 0;
  typedef struct {logic [W:0] exp; int acc; bit ce;} exp_t;
  exp_t sb[$];
  bit busy = 0, seen = 0;
  int acc = 0, k;
  logic [W-1:0] ma, mb;
`ifdef SERIAL_ADD_DRIVER_CHECK_EN
  logic chk_err;
`endif

  serial_add_driver #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .ser_clr(ser_clr), .ser_a(ser_a), .ser_b(ser_b),
    .ser_sum(ser_sum), .ser_carry(ser_carry), .res_valid(res_valid),
    .res_ready(res_ready), .result(result)
`ifdef SERIAL_ADD_DRIVER_CHECK_EN
    , .chk_err(chk_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // registered bit-serial full adder with synchronous clear
  always @(posedge clk)
    if (ser_clr) begin
      add_s <= 0;
      add_c <= 0;
    end else begin
      add_s <= ser_a ^ ser_b ^ add_c;
      add_c <= (ser_a & ser_b) | (ser_a & add_c) | (ser_b & add_c);
    end
  assign ser_sum = force0 ? 1'b0 : add_s;
  assign ser_carry = add_c;

  always @(posedge clk) begin
    #1;
    res_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // monitor: protocol and serial-bit rules, result scoreboard
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      busy = 0;
      seen = 0;
    end else begin
      k = cyc - acc;
      check("start_ready", start_ready, !busy);
      check("ser_clr", ser_clr, busy && k == 1);
      check("ser_a", ser_a, (busy && k >= 2 && k <= W + 1) ? ma[k-2] : 1'b0);
      check("ser_b", ser_b, (busy && k >= 2 && k <= W + 1) ? mb[k-2] : 1'b0);
      check("res_valid", res_valid, busy && k >= W + 3);
`ifdef SERIAL_ADD_DRIVER_CHECK_EN
      check("chk_err", chk_err, res_valid && !seen && sb.size() > 0 && sb[0].ce);
`endif
      if (res_valid) begin
        if (sb.size() == 0) check("res_unexpected", 1, 0);
        else begin
          check("result", result, sb[0].exp);
          if (!seen) check("latency", cyc - sb[0].acc, W + 3);
          seen = 1;
          if (res_ready) begin
            void'(sb.pop_front());
            busy = 0;
            seen = 0;
          end
        end
      end
      if (start_valid && start_ready) begin
        busy = 1;
        acc = cyc;
        ma = op_a;
        mb = op_b;
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] e, input bit ce);
    bit ok = 0;
    @(posedge clk);
    #1;
    start_valid = 1;
    op_a = a;
    op_b = b;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (start_ready) begin
        sb.push_back('{e, cyc, ce});
        ok = 1;
      end
    end
    if (!ok) check("start_timeout", 0, 1);
    @(posedge clk);
    #1;
    start_valid = 0;
    op_a = W'($urandom);
    op_b = W'($urandom);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
    do_op(a, b, {1'b0, a} + {1'b0, b}, 0);
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && sb.size() != 0; t++) @(negedge clk);
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_start_ready"}, start_ready, 0);
    check({tag, "_ser_clr"}, ser_clr, 1);
    check({tag, "_ser_a"}, ser_a, 0);
    check({tag, "_ser_b"}, ser_b, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_result"}, result, 0);
  endtask

  initial begin
    bit got;
    #2;
    reset_vals("por");
    repeat (2) @(posedge clk);
    #1 rst = 0;
    op(8'h05, 8'h03);
    drain();
    op(8'hFF, 8'h01);
    drain();
    hold = 1;
    op(8'hFF, 8'hFF);
    got = 0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = res_valid;
    end
    if (!got) check("hold_timeout", 0, 1);
    repeat (5) begin
      @(negedge clk);
      check("hold_result", result, 9'h1FE);
      check("hold_start_ready", start_ready, 0);
    end
    hold = 0;
    drain();
    op(8'h12, 8'h34);
    op(8'hAA, 8'h55);
    drain();
    for (int i = 0; i < 30; i++) begin
      op(W'($urandom), W'($urandom));
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();
    op(8'h3C, 8'h5A);
    repeat (5) @(posedge clk);
    #2 rst = 1;
    #1 reset_vals("mid_shift");
    @(negedge clk);
    @(posedge clk);
    #1 rst = 0;
    op(8'h01, 8'h01);
    drain();
`ifdef SERIAL_ADD_DRIVER_CHECK_EN
    force0 = 1;
    do_op(8'h0F, 8'h01, 9'h000, 1);
    drain();
    force0 = 0;
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
